// File: rtl/float_pkg.sv
// Shared constants, field positions and FSM encoding for the 8-bit float decoder.
package float_pkg;

    localparam int FLOAT_W = 8;
    localparam int INT_W   = 12;
    localparam int EXP_W   = 3;
    localparam int SIG_W   = 4;

    localparam int SIGN_POS = 7;
    localparam int EXP_HI   = 6;
    localparam int EXP_LO   = 4;
    localparam int SIG_HI   = 3;
    localparam int SIG_LO   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIX   = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Negative zero falls out naturally: ~0 + 1 wraps to 0 in INT_W bits.
    function automatic logic [INT_W-1:0] to_twos(input logic neg, input logic [INT_W-1:0] mag);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

endpackage

// File: rtl/float_decoder_if.sv
// Handshake bundle between the float producer and the decoder (DUT takes the slave side).
interface float_decoder_if;
    import float_pkg::*;

    logic [FLOAT_W-1:0] float_rep;
    logic               in_valid;
    logic               in_ready;
    logic [INT_W-1:0]   two_comp;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output float_rep, in_valid, out_ready,
        input  in_ready, two_comp, out_valid, busy
    );

    modport slave (
        input  float_rep, in_valid, out_ready,
        output in_ready, two_comp, out_valid, busy
    );
endinterface

// File: rtl/float_dec_shifter.sv
// Magnitude/exponent datapath: one-bit-per-cycle shifter, or a combinational
// barrel shift when FLOAT_DEC_FASTSHIFT_EN is defined.
module float_dec_shifter
    import float_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [SIG_W-1:0] sig_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [INT_W-1:0] mag_o,
    output logic             last_o
);

    logic [INT_W-1:0] mag_q, mag_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        mag_d = mag_q;
        cnt_d = cnt_q;
        if (load_i) begin
            mag_d = {{(INT_W-SIG_W){1'b0}}, sig_i};
            cnt_d = exp_i;
        end
`ifndef FLOAT_DEC_FASTSHIFT_EN
        else if (step_i) begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
            cnt_q <= '0;
        end else begin
            mag_q <= mag_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef FLOAT_DEC_FASTSHIFT_EN
    assign mag_o  = mag_q << cnt_q;
    assign last_o = 1'b1;
`else
    assign mag_o  = mag_q;
    assign last_o = (cnt_q == 3'd1);
`endif

endmodule

// File: rtl/float_decoder.sv
// Float (S EEE FFFF) to 12-bit two's-complement decoder: FSM and handshake.
// Optional FLOAT_DEC_FASTSHIFT_EN drops SHIFT for a 1-cycle barrel-shift decode.
module float_decoder
    import float_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    float_decoder_if.slave  fd
);

    state_e           state_q, state_d;
    logic             sign_q;
    logic [INT_W-1:0] two_comp_q;
    logic             out_valid_q;

    logic             load, step, fix;
    logic [INT_W-1:0] mag;
    logic             last;

    float_dec_shifter u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .sig_i  (fd.float_rep[SIG_HI:SIG_LO]),
        .exp_i  (fd.float_rep[EXP_HI:EXP_LO]),
        .mag_o  (mag),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fd.in_valid) begin
                    load = 1'b1;
`ifdef FLOAT_DEC_FASTSHIFT_EN
                    state_d = FIX;
`else
                    state_d = (fd.float_rep[EXP_HI:EXP_LO] != '0) ? SHIFT : FIX;
`endif
                end
            end
`ifndef FLOAT_DEC_FASTSHIFT_EN
            SHIFT: begin
                step = 1'b1;
                if (last) state_d = FIX;
            end
`endif
            FIX: begin
                fix     = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (fd.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            two_comp_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) sign_q <= fd.float_rep[SIGN_POS];
            if (fix) begin
                two_comp_q  <= to_twos(sign_q, mag);
                out_valid_q <= 1'b1;
            end else if (state_q == OUT && fd.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign fd.in_ready  = (state_q == IDLE);
    assign fd.busy      = (state_q != IDLE);
    assign fd.two_comp  = two_comp_q;
    assign fd.out_valid = out_valid_q;

endmodule

// File: doc/float_decoder.md
# float_decoder

Downstream consumer of the 12-bit-to-8-bit floating-point encoder stage. Accepts one 8-bit float word (S EEE FFFF, value = (−1)^S · F · 2^E) per valid/ready handshake and expands it back to a 12-bit two's-complement integer. Expansion uses an iterative one-bit-per-cycle shifter, so latency depends on the exponent. The block feeds the lab's display/compare logic and the round-trip checker.

## Interface
Parameters:
- none (widths fixed by the float format; constants live in the package)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high; clears all state
- float_rep  in  8  [7]=sign, [6:4]=exponent, [3:0]=significand
- in_valid  in  1  float_rep valid this cycle
- in_ready  out  1  block can accept; high only in IDLE
- two_comp  out  12  decoded two's-complement result; registered
- out_valid  out  1  two_comp valid; held until accepted
- out_ready  in  1  consumer accepts two_comp this cycle
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SHIFT, FIX, OUT.
- IDLE: in_ready=1. On in_valid at an edge, latch sign=float_rep[7], cnt=float_rep[6:4], mag={8'b0, float_rep[3:0]}. Go to SHIFT if exponent≠0, else FIX.
- SHIFT: each edge mag←mag<<1, cnt←cnt−1. Leave for FIX on the edge where cnt==1.
- FIX: on the edge, two_comp←sign ? (~mag+1) : mag; out_valid←1; go to OUT.
- OUT: hold two_comp and out_valid. On an edge with out_ready=1, out_valid←0 and go to IDLE. in_valid in OUT is ignored; in_ready=0.
- Arithmetic: max magnitude 15·2^7=1920 fits in 11 bits, so no saturation. Range is −1920..+1920.
- Negative zero (S=1, F=0, any E) decodes to 12'h000.
- float_rep is sampled only at the accept edge. Later changes have no effect on an in-flight decode.
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, two_comp=12'h000, mag=0, cnt=0, sign=0.
- Reset mid-operation (any state) aborts immediately. No output is produced for the aborted word.

## Timing
- Accept edge t0 (in_valid & in_ready).
- out_valid rises after edge t0+E+1: latency E+1 cycles, range 1..8.
- Minimum spacing between accepts is E+3 cycles (IDLE→…→OUT→IDLE, with out_ready held high).
- two_comp changes only at the FIX edge and is stable throughout OUT.
- out_valid falls on the edge where out_valid & out_ready are both high. in_ready rises the same edge.

## Configuration
- FLOAT_DEC_FASTSHIFT_EN defined: the SHIFT state is compiled out. IDLE goes straight to FIX, and FIX computes mag<<E with a combinational barrel shift. Latency is 1 cycle for every E; minimum accept spacing is 3 cycles.
- Undefined: iterative shifter as described above. Latency is E+1.
- Output values are identical in both builds.

## Structure
- Package float_pkg holds:
  - FLOAT_W=8, INT_W=12, EXP_W=3, SIG_W=4
  - field-position constants
  - the 2-bit state encoding (IDLE, SHIFT, FIX, OUT)
- Sub-module float_dec_shifter contains the mag/cnt datapath: iterative, or barrel under FLOAT_DEC_FASTSHIFT_EN. The top level keeps the FSM and handshake.

## Test plan
- float_rep=8'b0_101_1010 accepted at t0, out_ready=1 → out_valid high after edge t0+6, two_comp=12'd320 (12'h140).
- 8'b1_111_1111 → two_comp=12'h880 (−1920) after 8 cycles. 8'b0_111_1111 → 12'h780 (+1920).
- 8'b0_000_0000 → 12'h000 after 1 cycle. 8'b1_011_0000 → 12'h000 (negative zero).
- Backpressure: decode 8'b0_001_0011, hold out_ready=0 for 5 cycles → two_comp=12'd6 and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready → one transfer, then in_ready=1.
- Reset asserted asynchronously 2 cycles into SHIFT for 8'b0_110_0001 → all outputs at reset values immediately, no out_valid afterwards. Next word 8'b0_010_0101 → 12'd20.
- Sweep all 256 codes with random out_ready and compare against the reference model (−1)^S·F·2^E. With FLOAT_DEC_FASTSHIFT_EN, check the same values at 1-cycle latency.
